// File: rtl/iod_dly_train_ctrl_pkg.sv
// iod_dly_train_ctrl_pkg: shared FSM state encoding and delay-line move timing
package iod_dly_train_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_EVAL, S_STEP, S_CENTER, S_DONE, S_FAIL
  } state_t;
  localparam int MOVE_GAP = 2;
endpackage

// File: rtl/iod_dly_pulse_seq.sv
// iod_dly_pulse_seq: one MOVE pulse per request, direction set up a cycle early, then a MOVE_GAP quiet window
module iod_dly_pulse_seq
  import iod_dly_train_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic dir,
  output logic move,
  output logic direction,
  output logic done
);
  logic [2:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      move <= 1'b0;
      direction <= 1'b0;
      done <= 1'b0;
    end else begin
      move <= cnt == 3'd1;
      done <= cnt == 3'(MOVE_GAP + 1);
      if (cnt == '0) begin
        if (req) begin
          cnt <= 3'd1;
          direction <= dir;
        end
      end else cnt <= cnt == 3'(MOVE_GAP + 1) ? '0 : cnt + 3'd1;
    end
endmodule

// File: rtl/iod_dly_train_ctrl.sv
// iod_dly_train_ctrl: sweeps IOD delay taps, finds the passing eye and parks the delay at its center
module iod_dly_train_ctrl
  import iod_dly_train_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int MAX_TAPS = 128,
  parameter int MIN_WIDTH = 4
) (
  input  logic       fab_clk,
  input  logic       sync_rst,
  input  logic       start,
  input  logic       eye_monitor_early,
  input  logic       eye_monitor_late,
  input  logic       delay_line_out_of_range,
  output logic       delay_line_load,
  output logic       delay_line_move,
  output logic       delay_line_direction,
  output logic       eye_monitor_clear_flags,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [7:0] tap_pos,
  output logic [7:0] eye_left,
  output logic [8:0] eye_width
);
  state_t state;
  logic bad, oor_hit, seq_req, seq_done, pend, good, first, last;
  logic [7:0] scnt, center, ctr_n;
  logic [8:0] w_n;
  assign good = !(bad || oor_hit || delay_line_out_of_range);
  assign first = good && eye_width == '0;
  assign w_n = good ? eye_width + 9'd1 : eye_width;
  assign last = (!good && eye_width != '0) || tap_pos == 8'(MAX_TAPS - 1) || oor_hit || delay_line_out_of_range;
  assign ctr_n = (first ? tap_pos : eye_left) + 8'((w_n - 9'd1) >> 1);
  assign delay_line_load = state == S_LOAD;
  assign eye_monitor_clear_flags = state == S_CLEAR;
  assign busy = !(state inside {S_IDLE, S_DONE, S_FAIL});
  iod_dly_pulse_seq u_seq (
    .clk(fab_clk),
    .rst(sync_rst),
    .req(seq_req),
    .dir(state == S_STEP),
    .move(delay_line_move),
    .direction(delay_line_direction),
    .done(seq_done)
  );
  always_ff @(posedge fab_clk)
    if (sync_rst) begin
      state <= S_IDLE;
      done <= 1'b0;
      fail <= 1'b0;
      tap_pos <= '0;
      eye_left <= '0;
      eye_width <= '0;
      bad <= 1'b0;
      oor_hit <= 1'b0;
      scnt <= '0;
      center <= '0;
      seq_req <= 1'b0;
      pend <= 1'b0;
    end else begin
      seq_req <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_LOAD;
          done <= 1'b0;
          fail <= 1'b0;
        end
        S_LOAD: begin
          tap_pos <= '0;
          eye_width <= '0;
          pend <= 1'b0;
          state <= S_CLEAR;
        end
        S_CLEAR: begin
          bad <= 1'b0;
          oor_hit <= 1'b0;
          scnt <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          bad <= bad | eye_monitor_early | eye_monitor_late;
          oor_hit <= oor_hit | delay_line_out_of_range;
          scnt <= scnt + 8'd1;
          if (scnt == 8'(SETTLE_CYC - 1)) state <= S_EVAL;
        end
        S_EVAL: begin
          eye_width <= w_n;
          center <= ctr_n;
          if (first) eye_left <= tap_pos;
          if (!last) begin
            state <= S_STEP;
            seq_req <= 1'b1;
            tap_pos <= tap_pos + 8'd1;
          end else if (w_n < 9'(MIN_WIDTH)) begin
            state <= S_FAIL;
            fail <= 1'b1;
          end else state <= S_CENTER;
        end
        S_STEP: if (seq_done) state <= S_CLEAR;
        // each centering move is issued only once the previous one's gap has elapsed
        S_CENTER: if (delay_line_out_of_range) begin
          state <= S_FAIL;
          fail <= 1'b1;
        end else if (pend) pend <= !seq_done;
        else if (tap_pos == center) begin
          state <= S_DONE;
          done <= 1'b1;
        end else begin
          seq_req <= 1'b1;
          pend <= 1'b1;
          tap_pos <= tap_pos - 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_iod_dly_train_ctrl.sv
// tb_iod_dly_train_ctrl: randomized eye sweeps against a tap-level reference model with a scoreboard monitor
module tb_iod_dly_train_ctrl;
  localparam int MAXT = 128;
  localparam int MINW = 4;
  typedef struct {
    bit ok;
    int left, width, fin, incs, decs;
  } exp_t;
  logic fab_clk = 1'b0, sync_rst = 1'b1, start = 1'b0;
  logic early = 1'b0, late = 1'b0, oor = 1'b0;
  logic load, move, dir, clr, busy, done, fail;
  logic [7:0] tap_pos, eye_left;
  logic [8:0] eye_width;
  exp_t sb[$];
  exp_t mon_e;
  int vectors = 0, miscompares = 0;
  int eye_lo = 0, eye_hi = -1, oor_tap = -1, ptap = 0, incs = 0, decs = 0, since = 99;
  bit prev_clr = 0, prev_end = 0, prev_dir = 0, chk_after = 0, after_dir = 0;

  always #5 fab_clk = ~fab_clk;

  iod_dly_train_ctrl #(.SETTLE_CYC(8), .MAX_TAPS(MAXT), .MIN_WIDTH(MINW)) dut (
    .fab_clk(fab_clk),
    .sync_rst(sync_rst),
    .start(start),
    .eye_monitor_early(early),
    .eye_monitor_late(late),
    .delay_line_out_of_range(oor),
    .delay_line_load(load),
    .delay_line_move(move),
    .delay_line_direction(dir),
    .eye_monitor_clear_flags(clr),
    .busy(busy),
    .done(done),
    .fail(fail),
    .tap_pos(tap_pos),
    .eye_left(eye_left),
    .eye_width(eye_width)
  );

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference: walk taps in order, apply the good/bad/end rules directly
  function automatic exp_t model(int lo, int hi, int ot);
    exp_t e;
    int w = 0, left = 0, t;
    bit g;
    for (t = 0; t < MAXT; t++) begin
      g = t >= lo && t <= hi && t != ot;
      if (g) begin
        if (w == 0) left = t;
        w++;
      end
      if ((!g && w > 0) || t == MAXT - 1 || t == ot) break;
    end
    e.ok = w >= MINW;
    e.left = left;
    e.width = w;
    e.incs = t;
    e.fin = e.ok ? left + (w - 1) / 2 : t;
    e.decs = t - e.fin;
    return e;
  endfunction

  // delay-line / eye-monitor model plus output monitor
  initial forever begin
    @(posedge fab_clk);
    #1;
    if (load) begin
      ptap = 0;
      incs = 0;
      decs = 0;
    end
    if (chk_after) begin
      chk("dir_hold_after", dir, after_dir);
      chk_after = 0;
    end
    if (move) begin
      chk("dir_hold_before", dir, prev_dir);
      chk("move_gap", since >= 3, 1);
      ptap += dir ? 1 : -1;
      if (dir) incs++;
      else decs++;
      since = 0;
      chk_after = 1;
      after_dir = dir;
    end else since++;
    prev_dir = dir;
    early = ptap < eye_lo;
    late = ptap > eye_hi;
    oor = prev_clr && ptap == oor_tap;
    prev_clr = clr;
    if ((done || fail) && !prev_end) begin
      if (sb.size() == 0) chk("unexpected_end", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("done", done, mon_e.ok);
        chk("fail", fail, !mon_e.ok);
        chk("tap_pos", tap_pos, mon_e.fin);
        chk("phys_tap", ptap, mon_e.fin);
        chk("eye_width", eye_width, mon_e.width);
        if (mon_e.width > 0) chk("eye_left", eye_left, mon_e.left);
        chk("incs", incs, mon_e.incs);
        chk("decs", decs, mon_e.decs);
        chk("busy_end", busy, 0);
      end
    end
    prev_end = done || fail;
  end

  task automatic all_zero(string nm);
    chk({nm, "_outs"}, {load, move, dir, clr, busy, done, fail}, 0);
    chk({nm, "_tap"}, tap_pos, 0);
    chk({nm, "_left"}, eye_left, 0);
    chk({nm, "_width"}, eye_width, 0);
  endtask

  task automatic run(int lo, int hi, int ot, bit poke);
    bit fin = 0;
    eye_lo = lo;
    eye_hi = hi;
    oor_tap = ot;
    sb.push_back(model(lo, hi, ot));
    @(negedge fab_clk) start = 1;
    @(negedge fab_clk) start = 0;
    for (int c = 0; c < 6000 && !fin; c++) begin
      if (done || fail) fin = 1;
      else begin
        start = poke && c % 41 == 7;
        @(negedge fab_clk);
      end
    end
    start = 0;
    chk("run_end", fin, 1);
    if (!fin) begin
      sync_rst = 1;
      @(negedge fab_clk) sync_rst = 0;
      sb.delete();
    end
    repeat (3) @(negedge fab_clk);
  endtask

  initial begin
    int lo, w, ot, mv;
    repeat (3) @(negedge fab_clk);
    all_zero("reset");
    sync_rst = 0;
    repeat (2) @(negedge fab_clk);
    run(10, 29, -1, 0);
    run(5, 6, -1, 0);
    run(120, 200, -1, 0);
    run(10, 40, 15, 0);
    run(20, 35, -1, 1);
    for (int i = 0; i < 14; i++) begin
      lo = $urandom_range(0, 40);
      w = $urandom_range(0, 12);
      ot = $urandom_range(0, 3) == 0 ? int'($urandom_range(lo, lo + 15)) : -1;
      run(lo, lo + w - 1, ot, $urandom_range(0, 1) == 1);
    end
    eye_lo = 10;
    eye_hi = 29;
    oor_tap = -1;
    @(negedge fab_clk) start = 1;
    @(negedge fab_clk) start = 0;
    for (int c = 0; c < 3000 && tap_pos != 7; c++) @(negedge fab_clk);
    chk("reach_tap7", tap_pos, 7);
    sync_rst = 1;
    @(negedge fab_clk) sync_rst = 0;
    all_zero("midsweep_rst");
    mv = 0;
    repeat (40) begin
      @(negedge fab_clk);
      mv += int'(move);
    end
    chk("no_move_after_rst", mv, 0);
    sync_rst = 1;
    start = 1;
    @(negedge fab_clk);
    sync_rst = 0;
    start = 0;
    @(negedge fab_clk);
    chk("rst_beats_start", busy, 0);
    run(30, 45, -1, 0);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
